// File: rtl/instruction_fetch_stage_if.sv
// ============================================================================
//  Module   : instruction_fetch_stage_if
//  Purpose  : Bundles the instruction-memory request/response channel, the
//             redirect/halt controls and the decode-side valid/ready channel
//             of the fetch stage.
//  Modports : master - the fetch stage (drives requests and fetch output)
//             slave  - the environment (memory, execute and decode stages)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instruction_fetch_stage_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        halt;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [31:0] fetch_instr;
   logic [63:0] fetch_pc;

   modport master (
      output imem_req_valid, imem_req_addr, fetch_valid, fetch_instr, fetch_pc,
      input  imem_req_ready, imem_resp_valid, imem_resp_data,
      input  redirect_valid, redirect_pc, halt, fetch_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, fetch_valid, fetch_instr, fetch_pc,
      output imem_req_ready, imem_resp_valid, imem_resp_data,
      output redirect_valid, redirect_pc, halt, fetch_ready
   );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch_stage.sv
// ============================================================================
//  Module   : instruction_fetch_stage
//  Purpose  : RV64I fetch stage. Holds the fetch PC, issues in-order 32-bit
//             instruction reads, buffers responses with their PCs in a FIFO
//             and hands them to decode over valid/ready. Redirects flush the
//             buffer and discard responses to wrong-path requests in flight.
//  Ports    : clk  - clock, rising edge
//             rst  - asynchronous reset, active-high
//             bus  - instruction_fetch_stage_if.master (imem req/resp,
//                    redirect, halt, fetch output channel)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_stage #(
   parameter logic [63:0] RESET_PC        = 64'h0,
   parameter int          FIFO_DEPTH      = 4,
   parameter int          MAX_OUTSTANDING = 2
) (
   input wire logic                   clk,
   input wire logic                   rst,
   instruction_fetch_stage_if.master  bus
);

   localparam int c_PTR_W = $clog2(FIFO_DEPTH);
   localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int c_IFQ_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   logic [63:0]        r_pc;
   logic [c_CNT_W-1:0] r_out_cnt;
   logic [c_CNT_W-1:0] r_drop;

   // PCs of accepted requests, oldest first; occupancy equals r_out_cnt
   logic [63:0]        r_ifq [MAX_OUTSTANDING];
   logic [c_IFQ_W-1:0] r_ifq_wr;
   logic [c_IFQ_W-1:0] r_ifq_rd;

   // Instruction buffer; pointers carry one extra bit to tell full from empty
   logic [31:0]        r_fifo_instr [FIFO_DEPTH];
   logic [63:0]        r_fifo_pc    [FIFO_DEPTH];
   logic [c_PTR_W:0]   r_wr_ptr;
   logic [c_PTR_W:0]   r_rd_ptr;

   logic [c_PTR_W:0]   w_fifo_count;
   logic               w_fifo_empty;
   logic [31:0]        w_used;
   logic               w_req_valid;
   logic               w_fire;
   logic               w_push;
   logic               w_pop;
   logic               w_fetch_valid;
   logic [63:0]        w_redir_pc;

   function automatic logic [c_IFQ_W-1:0] ifq_next(input logic [c_IFQ_W-1:0] idx);
      // Explicit wrap so MAX_OUTSTANDING need not be a power of two
      if (idx == c_IFQ_W'(MAX_OUTSTANDING - 1)) return '0;
      return idx + c_IFQ_W'(1);
   endfunction

   assign w_fifo_count = r_wr_ptr - r_rd_ptr;
   assign w_fifo_empty = (w_fifo_count == '0);
   // Every outstanding request holds a credit for a buffer slot, so a
   // response can always be enqueued without backpressure.
   assign w_used       = 32'(r_out_cnt) + 32'(w_fifo_count);
   assign w_req_valid  = !rst && !bus.halt && !bus.redirect_valid
                         && (32'(r_out_cnt) < 32'(MAX_OUTSTANDING))
                         && (w_used < 32'(FIFO_DEPTH));
   assign w_fire       = w_req_valid && bus.imem_req_ready;
   // The redirect flush wins over any enqueue in the same cycle
   assign w_push        = bus.imem_resp_valid && !bus.redirect_valid && (r_drop == '0);
   assign w_fetch_valid = !w_fifo_empty && !bus.redirect_valid;
   assign w_pop         = w_fetch_valid && bus.fetch_ready;
   assign w_redir_pc    = bus.redirect_pc & ~64'h3;

   assign bus.imem_req_valid = w_req_valid;
   assign bus.imem_req_addr  = r_pc;
   assign bus.fetch_valid    = w_fetch_valid;
   assign bus.fetch_instr    = r_fifo_instr[r_rd_ptr[c_PTR_W-1:0]];
   assign bus.fetch_pc       = r_fifo_pc[r_rd_ptr[c_PTR_W-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc      <= RESET_PC;
         r_out_cnt <= '0;
         r_drop    <= '0;
         r_ifq_wr  <= '0;
         r_ifq_rd  <= '0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) r_ifq[i] <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_fifo_instr[i] <= '0;
            r_fifo_pc[i]    <= '0;
         end
      end else begin
         // Fetch PC
         if (bus.redirect_valid)
            r_pc <= w_redir_pc;
         else if (w_fire)
            r_pc <= r_pc + 64'd4;

         // Outstanding count
         if (w_fire && !bus.imem_resp_valid)
            r_out_cnt <= r_out_cnt + c_CNT_W'(1);
         else if (!w_fire && bus.imem_resp_valid)
            r_out_cnt <= r_out_cnt - c_CNT_W'(1);

         // Wrong-path responses still owed by memory; the response arriving
         // in the redirect cycle is discarded directly, hence not counted.
         if (bus.redirect_valid)
            r_drop <= r_out_cnt - c_CNT_W'(bus.imem_resp_valid);
         else if (bus.imem_resp_valid && (r_drop != '0))
            r_drop <= r_drop - c_CNT_W'(1);

         // In-flight PC queue keeps running across redirects
         if (w_fire) begin
            r_ifq[r_ifq_wr] <= r_pc;
            r_ifq_wr        <= ifq_next(r_ifq_wr);
         end
         if (bus.imem_resp_valid)
            r_ifq_rd <= ifq_next(r_ifq_rd);

         // Instruction buffer
         if (bus.redirect_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push) begin
               r_fifo_instr[r_wr_ptr[c_PTR_W-1:0]] <= bus.imem_resp_data;
               r_fifo_pc[r_wr_ptr[c_PTR_W-1:0]]    <= r_ifq[r_ifq_rd];
               r_wr_ptr                            <= r_wr_ptr + 1'b1;
            end
            if (w_pop)
               r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   a_fifo_bound : assert property (@(posedge clk) disable iff (rst)
      32'(w_fifo_count) <= 32'(FIFO_DEPTH));
   a_resp_expected : assert property (@(posedge clk) disable iff (rst)
      bus.imem_resp_valid |-> (r_out_cnt != '0));
   a_drop_bound : assert property (@(posedge clk) disable iff (rst)
      (r_drop <= r_out_cnt) && (32'(r_out_cnt) <= 32'(MAX_OUTSTANDING)));

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
// ============================================================================
//  Module   : tb_instruction_fetch_stage
//  Purpose  : Randomized self-checking bench for instruction_fetch_stage.
//             A latency-randomized memory answers requests in order; a
//             queue-based reference model predicts every output each cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_stage;

   localparam logic [63:0] RPC = 64'h1000;
   localparam int          FD  = 4;
   localparam int          MO  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   instruction_fetch_stage_if bus ();

   instruction_fetch_stage #(
      .RESET_PC        (RPC),
      .FIFO_DEPTH      (FD),
      .MAX_OUTSTANDING (MO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   longint      cyc     = 0;

   // Reference model: next fetch address, PCs in flight, wrong-path
   // responses still to discard, and buffered PCs in delivery order.
   logic [63:0] m_pc;
   logic [63:0] m_infl[$];
   int          m_stale;
   logic [63:0] m_fifo[$];

   // Memory model: accepted addresses and the cycle each answer is due
   logic [63:0] mem_addr_q[$];
   longint      mem_due_q[$];

   int p_rdy, p_frdy, p_redir, p_halt, lat_max;
   bit rst_armed = 1'b0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
   endfunction

   function automatic bit pct(input int p);
      return int'($urandom_range(99, 0)) < p;
   endfunction

   function automatic logic [63:0] rand_target();
      case ($urandom_range(2, 0))
         0:       return 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0));
         1:       return 64'h2000 + 64'($urandom_range(255, 0));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   task automatic model_reset();
      m_pc    = RPC;
      m_stale = 0;
      m_infl.delete();
      m_fifo.delete();
      mem_addr_q.delete();
      mem_due_q.delete();
   endtask

   task automatic idle_inputs();
      bus.imem_req_ready  = 1'b0;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
      bus.redirect_valid  = 1'b0;
      bus.redirect_pc     = '0;
      bus.fetch_ready     = 1'b0;
   endtask

   task automatic do_cycle();
      bit          exp_req, exp_fv, fire, pop, resp, redir;
      logic [63:0] rpc, pc;
      longint      due;
      @(negedge clk);
      cyc++;
      bus.imem_req_ready = pct(p_rdy);
      bus.fetch_ready    = pct(p_frdy);
      bus.redirect_valid = pct(p_redir);
      bus.redirect_pc    = rand_target();
      if (pct(p_halt)) bus.halt = !bus.halt;
      if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
         bus.imem_resp_valid = 1'b1;
         bus.imem_resp_data  = mem_word(mem_addr_q[0]);
      end else begin
         bus.imem_resp_valid = 1'b0;
         bus.imem_resp_data  = $urandom;
      end
      #1;
      resp  = bus.imem_resp_valid;
      redir = bus.redirect_valid;
      rpc   = bus.redirect_pc;
      exp_req = !bus.halt && !redir && (m_infl.size() < MO)
                && (m_infl.size() + m_fifo.size() < FD);
      exp_fv  = (m_fifo.size() > 0) && !redir;
      chk("req_valid",   64'(bus.imem_req_valid), 64'(exp_req));
      chk("req_addr",    bus.imem_req_addr, m_pc);
      chk("fetch_valid", 64'(bus.fetch_valid), 64'(exp_fv));
      if (m_fifo.size() > 0) begin
         chk("fetch_pc",    bus.fetch_pc, m_fifo[0]);
         chk("fetch_instr", 64'(bus.fetch_instr), 64'(mem_word(m_fifo[0])));
      end

      if (rst_armed && m_fifo.size() >= 3) begin
         // Asynchronous reset pulse entirely between two clock edges
         rst_armed = 1'b0;
         idle_inputs();
         #1 rst = 1'b1;
         #1;
         chk("rst_req_valid",   64'(bus.imem_req_valid), 64'd0);
         chk("rst_fetch_valid", 64'(bus.fetch_valid), 64'd0);
         chk("rst_req_addr",    bus.imem_req_addr, RPC);
         chk("rst_fetch_pc",    bus.fetch_pc, 64'd0);
         chk("rst_fetch_instr", 64'(bus.fetch_instr), 64'd0);
         #1 rst = 1'b0;
         model_reset();
         return;
      end

      fire = exp_req && bus.imem_req_ready;
      pop  = exp_fv && bus.fetch_ready;
      if (pop) void'(m_fifo.pop_front());
      if (resp) begin
         pc = m_infl.pop_front();
         void'(mem_addr_q.pop_front());
         void'(mem_due_q.pop_front());
         if (!redir) begin
            if (m_stale > 0) m_stale--;
            else             m_fifo.push_back(pc);
         end
      end
      if (redir) begin
         m_fifo.delete();
         m_stale = m_infl.size();
         m_pc    = {rpc[63:2], 2'b00};
      end
      if (fire) begin
         due = cyc + longint'($urandom_range(lat_max, 1));
         if (mem_due_q.size() > 0 && due <= mem_due_q[$]) due = mem_due_q[$] + 1;
         m_infl.push_back(m_pc);
         mem_addr_q.push_back(m_pc);
         mem_due_q.push_back(due);
         m_pc = m_pc + 64'd4;
      end
   endtask

   task automatic run_phase(input int n, input int rdy, input int frdy,
                            input int redir, input int hlt, input int lat);
      p_rdy = rdy; p_frdy = frdy; p_redir = redir; p_halt = hlt; lat_max = lat;
      for (int i = 0; i < n; i++) do_cycle();
   endtask

   initial begin
      idle_inputs();
      bus.halt = 1'b0;
      model_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("init_req_valid",   64'(bus.imem_req_valid), 64'd0);
      chk("init_fetch_valid", 64'(bus.fetch_valid), 64'd0);
      chk("init_req_addr",    bus.imem_req_addr, RPC);
      chk("init_fetch_pc",    bus.fetch_pc, 64'd0);
      chk("init_fetch_instr", 64'(bus.fetch_instr), 64'd0);
      rst = 1'b0;

      // Straight-line fetch, latency 1, decode always ready
      run_phase(40, 100, 100, 0, 0, 1);
      // Decode stalls long enough to fill the buffer, then drains
      run_phase(20, 100, 0, 0, 0, 1);
      run_phase(20, 100, 100, 0, 0, 1);
      // Fill again and pulse reset with the buffer mostly full
      rst_armed = 1'b1;
      run_phase(12, 100, 0, 0, 0, 2);
      run_phase(20, 100, 100, 0, 0, 1);
      // Redirects with long latency and responses in flight
      run_phase(300, 100, 80, 10, 0, 3);
      // Everything randomized, including halt toggling
      run_phase(600, 70, 70, 6, 5, 3);
      run_phase(400, 50, 30, 15, 8, 3);
      bus.halt = 1'b0;
      // Mid-stream reset under random traffic
      rst_armed = 1'b1;
      run_phase(200, 80, 40, 4, 0, 2);
      run_phase(100, 100, 100, 0, 0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
